// File: rtl/ariane.sv
// Single-outstanding instruction fetch front end with trap, interrupt, MRET/DRET and debug redirection.
// Define RVFI_TRACE_EN to add registered retirement trace ports (trace_valid_o/trace_pc_o/trace_insn_o).
module ariane #(
  parameter logic [31:0] TRAP_VEC  = 32'h0000_0100,
  parameter logic [31:0] DEBUG_VEC = 32'h0000_0800
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] boot_addr_i,
  input  logic [63:0] hart_id_i,
  input  logic [1:0]  irq_i,
  input  logic        ipi_i,
  input  logic        time_irq_i,
  input  logic        debug_req_i,
  output logic        ar_valid_o,
  input  logic        ar_ready_i,
  output logic [31:0] ar_addr_o,
  output logic [3:0]  ar_id_o,
  input  logic        r_valid_i,
  output logic        r_ready_o,
  input  logic [31:0] r_data_i,
  input  logic [1:0]  r_resp_i,
  output logic [31:0] mcause_o,
  output logic [31:0] mepc_o,
  output logic        debug_mode_o
`ifdef RVFI_TRACE_EN
  ,
  output logic        trace_valid_o,
  output logic [31:0] trace_pc_o,
  output logic [31:0] trace_insn_o
`endif
);

  typedef enum logic {FETCH_REQ, FETCH_WAIT} state_e;

  localparam logic [31:0] INSN_MRET = 32'h3020_0073;
  localparam logic [31:0] INSN_DRET = 32'h7b20_0073;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] mcause_q, mcause_d;
  logic [31:0] mepc_q, mepc_d;
  logic [31:0] dpc_q, dpc_d;
  logic        ie_q, ie_d;
  logic        debug_mode_q, debug_mode_d;
  logic        retire;
  logic [31:0] seq_pc;
  logic        irq_pending;
  logic [30:0] irq_code;
  logic        unused_hart_bits;

  assign seq_pc           = pc_q + 32'd4;
  assign irq_pending      = (|irq_i) | ipi_i | time_irq_i;
  assign unused_hart_bits = ^hart_id_i[63:4];

  // Fixed cause priority: machine external, software, timer, supervisor external.
  always_comb begin
    if (irq_i[0])        irq_code = 31'd11;
    else if (ipi_i)      irq_code = 31'd3;
    else if (time_irq_i) irq_code = 31'd7;
    else                 irq_code = 31'd9;
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    mcause_d     = mcause_q;
    mepc_d       = mepc_q;
    dpc_d        = dpc_q;
    ie_d         = ie_q;
    debug_mode_d = debug_mode_q;
    retire       = 1'b0;
    case (state_q)
      FETCH_REQ: begin
        if (ar_ready_i) state_d = FETCH_WAIT;
      end
      FETCH_WAIT: begin
        if (r_valid_i) begin
          state_d = FETCH_REQ;
          if (r_resp_i != 2'b00) begin
            mcause_d = 32'd1;
            mepc_d   = pc_q;
            pc_d     = TRAP_VEC;
            ie_d     = 1'b0;
          end else begin
            retire = 1'b1;
            if (debug_req_i && !debug_mode_q) begin
              dpc_d        = seq_pc;
              pc_d         = DEBUG_VEC;
              debug_mode_d = 1'b1;
            end else if (r_data_i == INSN_MRET) begin
              pc_d = mepc_q;
              ie_d = 1'b1;
            end else if (r_data_i == INSN_DRET && debug_mode_q) begin
              pc_d         = dpc_q;
              debug_mode_d = 1'b0;
            end else if (ie_q && !debug_mode_q && irq_pending) begin
              mcause_d = {1'b1, irq_code};
              mepc_d   = seq_pc;
              pc_d     = TRAP_VEC;
              ie_d     = 1'b0;
            end else begin
              pc_d = seq_pc;
            end
          end
        end
      end
      default: state_d = FETCH_REQ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= FETCH_REQ;
      pc_q         <= boot_addr_i;
      mcause_q     <= 32'd0;
      mepc_q       <= 32'd0;
      dpc_q        <= 32'd0;
      ie_q         <= 1'b1;
      debug_mode_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      mcause_q     <= mcause_d;
      mepc_q       <= mepc_d;
      dpc_q        <= dpc_d;
      ie_q         <= ie_d;
      debug_mode_q <= debug_mode_d;
    end
  end

  // Handshake outputs are masked during reset so an abandoned fetch cannot complete.
  assign ar_valid_o   = (state_q == FETCH_REQ) && !rst_i;
  assign r_ready_o    = (state_q == FETCH_WAIT) && !rst_i;
  assign ar_addr_o    = pc_q;
  assign ar_id_o      = hart_id_i[3:0];
  assign mcause_o     = mcause_q;
  assign mepc_o       = mepc_q;
  assign debug_mode_o = debug_mode_q;

`ifdef RVFI_TRACE_EN
  logic        trace_valid_q, trace_valid_d;
  logic [31:0] trace_pc_q, trace_pc_d;
  logic [31:0] trace_insn_q, trace_insn_d;

  always_comb begin
    trace_valid_d = retire;
    trace_pc_d    = retire ? pc_q : trace_pc_q;
    trace_insn_d  = retire ? r_data_i : trace_insn_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      trace_valid_q <= 1'b0;
      trace_pc_q    <= 32'd0;
      trace_insn_q  <= 32'd0;
    end else begin
      trace_valid_q <= trace_valid_d;
      trace_pc_q    <= trace_pc_d;
      trace_insn_q  <= trace_insn_d;
    end
  end

  assign trace_valid_o = trace_valid_q;
  assign trace_pc_o    = trace_pc_q;
  assign trace_insn_o  = trace_insn_q;
`endif

endmodule

// File: tb/tb_ariane.sv
// Scoreboard bench for ariane: a driver plays memory and a spec-level model, a monitor checks each fetch request.
module tb_ariane;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] MRET = 32'h3020_0073;
  localparam logic [31:0] DRET = 32'h7b20_0073;
  localparam logic [31:0] TRAP = 32'h0000_0100;
  localparam logic [31:0] DBGV = 32'h0000_0800;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [31:0] boot_addr_i = 32'd0;
  logic [63:0] hart_id_i = 64'h1234_5678_9abc_def5;
  logic [1:0]  irq_i = 2'b00;
  logic        ipi_i = 1'b0;
  logic        time_irq_i = 1'b0;
  logic        debug_req_i = 1'b0;
  logic        ar_valid_o;
  logic        ar_ready_i = 1'b0;
  logic [31:0] ar_addr_o;
  logic [3:0]  ar_id_o;
  logic        r_valid_i = 1'b0;
  logic        r_ready_o;
  logic [31:0] r_data_i = 32'd0;
  logic [1:0]  r_resp_i = 2'b00;
  logic [31:0] mcause_o;
  logic [31:0] mepc_o;
  logic        debug_mode_o;
`ifdef RVFI_TRACE_EN
  logic        trace_valid_o;
  logic [31:0] trace_pc_o;
  logic [31:0] trace_insn_o;
`endif

  ariane dut (
    .clk_i(clk_i), .rst_i(rst_i), .boot_addr_i(boot_addr_i), .hart_id_i(hart_id_i),
    .irq_i(irq_i), .ipi_i(ipi_i), .time_irq_i(time_irq_i), .debug_req_i(debug_req_i),
    .ar_valid_o(ar_valid_o), .ar_ready_i(ar_ready_i), .ar_addr_o(ar_addr_o), .ar_id_o(ar_id_o),
    .r_valid_i(r_valid_i), .r_ready_o(r_ready_o), .r_data_i(r_data_i), .r_resp_i(r_resp_i),
    .mcause_o(mcause_o), .mepc_o(mepc_o), .debug_mode_o(debug_mode_o)
`ifdef RVFI_TRACE_EN
    , .trace_valid_o(trace_valid_o), .trace_pc_o(trace_pc_o), .trace_insn_o(trace_insn_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] mcause;
    logic [31:0] mepc;
    logic        dbg;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
`ifdef RVFI_TRACE_EN
  typedef struct {
    logic [31:0] pc;
    logic [31:0] insn;
  } tr_t;
  tr_t tr_q[$];
  tr_t tr_e;
`endif

  int n_checks = 0;
  int n_fails  = 0;

  // Architectural reference state
  logic [31:0] m_pc, m_mcause, m_mepc, m_dpc;
  logic        m_ie, m_dbg;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, expv);
    end
  endtask

  task automatic finish_test();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_fails++;
    $display("[TB] FAIL %s: timeout waiting for DUT", name);
    finish_test();
  endtask

  // Every accepted fetch request must match the next queued expectation.
  always @(negedge clk_i) begin
    if (!rst_i && ar_valid_o && ar_ready_i) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fails++;
        $display("[TB] FAIL unexpected_fetch: got addr 0x%08h, expected no request", ar_addr_o);
      end else begin
        mon_e = exp_q.pop_front();
        check_output("ar_addr", ar_addr_o, mon_e.addr);
        check_output("mcause", mcause_o, mon_e.mcause);
        check_output("mepc", mepc_o, mon_e.mepc);
        check_output("debug_mode", {31'd0, debug_mode_o}, {31'd0, mon_e.dbg});
      end
    end
  end

`ifdef RVFI_TRACE_EN
  always @(negedge clk_i) begin
    if (trace_valid_o) begin
      if (tr_q.size() == 0) begin
        n_checks++;
        n_fails++;
        $display("[TB] FAIL unexpected_trace: got pc 0x%08h, expected no pulse", trace_pc_o);
      end else begin
        tr_e = tr_q.pop_front();
        check_output("trace_pc", trace_pc_o, tr_e.pc);
        check_output("trace_insn", trace_insn_o, tr_e.insn);
      end
    end
  end
`endif

  function automatic logic [31:0] pick_cause(input logic [1:0] irqv, input logic ipi, input logic tim);
    int codes[4];
    logic srcs[4];
    codes = '{11, 3, 7, 9};
    srcs  = '{irqv[0], ipi, tim, irqv[1]};
    for (int k = 0; k < 4; k++)
      if (srcs[k]) return 32'h8000_0000 | 32'(codes[k]);
    return 32'd0;
  endfunction

  task automatic model_complete(input logic [1:0] resp, input logic [31:0] data, input logic [1:0] irqv,
                                input logic ipi, input logic tim, input logic dbg);
    logic [31:0] seq;
    logic [31:0] old_pc;
    exp_t e;
    old_pc = m_pc;
    seq    = m_pc + 32'd4;
    if (resp != 2'b00) begin
      m_mcause = 32'd1; m_mepc = m_pc; m_pc = TRAP; m_ie = 1'b0;
    end else if (dbg && !m_dbg) begin
      m_dpc = seq; m_pc = DBGV; m_dbg = 1'b1;
    end else if (data == MRET) begin
      m_pc = m_mepc; m_ie = 1'b1;
    end else if (data == DRET && m_dbg) begin
      m_pc = m_dpc; m_dbg = 1'b0;
    end else if (m_ie && !m_dbg && (irqv != 2'b00 || ipi || tim)) begin
      m_mcause = pick_cause(irqv, ipi, tim); m_mepc = seq; m_pc = TRAP; m_ie = 1'b0;
    end else begin
      m_pc = seq;
    end
`ifdef RVFI_TRACE_EN
    if (resp == 2'b00) tr_q.push_back('{pc: old_pc, insn: data});
`else
    if (old_pc === 32'hx) m_pc = m_pc;
`endif
    e.addr = m_pc; e.mcause = m_mcause; e.mepc = m_mepc; e.dbg = m_dbg;
    exp_q.push_back(e);
  endtask

  task automatic do_reset(input logic [31:0] boot);
    exp_t e;
    rst_i = 1'b1; boot_addr_i = boot;
    ar_ready_i = 1'b0; r_valid_i = 1'b0; r_resp_i = 2'b00;
    irq_i = 2'b00; ipi_i = 1'b0; time_irq_i = 1'b0; debug_req_i = 1'b0;
    @(posedge clk_i); #1;
    check_output("reset_ar_valid", {31'd0, ar_valid_o}, 32'd0);
    check_output("reset_r_ready", {31'd0, r_ready_o}, 32'd0);
    check_output("reset_mcause", mcause_o, 32'd0);
    check_output("reset_mepc", mepc_o, 32'd0);
    check_output("reset_debug_mode", {31'd0, debug_mode_o}, 32'd0);
    @(posedge clk_i); #1;
`ifdef RVFI_TRACE_EN
    check_output("reset_trace_valid", {31'd0, trace_valid_o}, 32'd0);
    tr_q.delete();
`endif
    exp_q.delete();
    m_pc = boot; m_mcause = 32'd0; m_mepc = 32'd0; m_dpc = 32'd0; m_ie = 1'b1; m_dbg = 1'b0;
    e.addr = boot; e.mcause = 32'd0; e.mepc = 32'd0; e.dbg = 1'b0;
    exp_q.push_back(e);
    rst_i = 1'b0;
    #1;
    check_output("first_ar_valid", {31'd0, ar_valid_o}, 32'd1);
    check_output("first_ar_addr", ar_addr_o, boot);
  endtask

  // Waits for the request, accepts it at the next edge; returns just after that edge.
  task automatic accept_request(input int ar_stall);
    int waited;
    ar_ready_i = 1'b0;
    for (int i = 0; i < ar_stall; i++) begin
      @(posedge clk_i); #1;
      check_output("stall_ar_valid", {31'd0, ar_valid_o}, 32'd1);
      check_output("stall_ar_addr", ar_addr_o, m_pc);
    end
    ar_ready_i = 1'b1;
    waited = 0;
    while (!ar_valid_o) begin
      @(posedge clk_i); #1;
      waited++;
      if (waited > 20) timeout("ar_handshake");
    end
    @(posedge clk_i); #1;
    ar_ready_i = 1'b0;
  endtask

  task automatic apply_stimulus(input logic [1:0] resp, input logic [31:0] data, input logic [1:0] irqv,
                                input logic ipi, input logic tim, input logic dbg,
                                input int ar_stall, input int r_stall);
    int waited;
    accept_request(ar_stall);
    irq_i = irqv; ipi_i = ipi; time_irq_i = tim; debug_req_i = dbg;
    for (int i = 0; i < r_stall; i++) begin
      @(posedge clk_i); #1;
    end
    r_valid_i = 1'b1; r_data_i = data; r_resp_i = resp;
    waited = 0;
    while (!r_ready_o) begin
      @(posedge clk_i); #1;
      waited++;
      if (waited > 20) timeout("r_handshake");
    end
    @(posedge clk_i); #1;
    r_valid_i = 1'b0; r_resp_i = 2'b00; r_data_i = $urandom;
    model_complete(resp, data, irqv, ipi, tim, dbg);
  endtask

  initial begin
    logic [1:0]  rr, ri;
    logic [31:0] rd;
    int          sel;
    int          waited;

    do_reset(32'h8000_0000);
    check_output("ar_id", {28'd0, ar_id_o}, 32'h5);
    for (int i = 0; i < 3; i++) apply_stimulus(2'b00, NOP, 2'b00, 1'b0, 1'b0, 1'b0, 0, 0);

    do_reset(32'hFFFF_FFFC);
    apply_stimulus(2'b00, NOP, 2'b00, 1'b0, 1'b0, 1'b0, 0, 1);

    do_reset(32'h0000_0100);
    apply_stimulus(2'b00, NOP, 2'b00, 1'b0, 1'b1, 1'b0, 0, 0);
    apply_stimulus(2'b00, MRET, 2'b00, 1'b0, 1'b0, 1'b0, 1, 0);
    apply_stimulus(2'b00, NOP, 2'b01, 1'b1, 1'b0, 1'b0, 0, 2);
    apply_stimulus(2'b00, MRET, 2'b00, 1'b0, 1'b0, 1'b0, 0, 0);
    apply_stimulus(2'b00, NOP, 2'b10, 1'b0, 1'b1, 1'b0, 0, 0);

    do_reset(32'h0000_0200);
    apply_stimulus(2'b10, NOP, 2'b00, 1'b0, 1'b0, 1'b0, 0, 0);
    apply_stimulus(2'b00, NOP, 2'b00, 1'b0, 1'b0, 1'b0, 0, 0);

    do_reset(32'h0000_0300);
    apply_stimulus(2'b00, NOP, 2'b00, 1'b0, 1'b1, 1'b1, 0, 0);
    apply_stimulus(2'b00, DRET, 2'b00, 1'b0, 1'b1, 1'b0, 0, 0);
    apply_stimulus(2'b00, NOP, 2'b00, 1'b0, 1'b1, 1'b0, 0, 0);
    apply_stimulus(2'b00, DRET, 2'b00, 1'b0, 1'b0, 1'b0, 5, 0);

    // Reset while waiting for data: the late response must not be consumed.
    accept_request(0);
    do_reset(32'h0000_4000);
    r_valid_i = 1'b1; r_data_i = MRET;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_i); #1;
      check_output("late_r_ready", {31'd0, r_ready_o}, 32'd0);
      check_output("late_ar_addr", ar_addr_o, 32'h0000_4000);
    end
    r_valid_i = 1'b0;
    apply_stimulus(2'b00, NOP, 2'b00, 1'b0, 1'b0, 1'b0, 0, 0);

    do_reset($urandom & 32'hFFFF_FFFC);
    for (int n = 0; n < 150; n++) begin
      rr  = ($urandom_range(7) == 0) ? 2'($urandom_range(3, 1)) : 2'b00;
      sel = $urandom_range(9);
      rd  = (sel < 5) ? NOP : (sel == 5) ? MRET : (sel == 6) ? DRET : $urandom;
      ri  = {($urandom_range(5) == 0), ($urandom_range(5) == 0)};
      apply_stimulus(rr, rd, ri, $urandom_range(5) == 0, $urandom_range(5) == 0,
                     $urandom_range(7) == 0, $urandom_range(2), $urandom_range(2));
    end

    irq_i = 2'b00; ipi_i = 1'b0; time_irq_i = 1'b0; debug_req_i = 1'b0;
    ar_ready_i = 1'b1;
    waited = 0;
    while (exp_q.size() != 0 && waited < 20) begin
      @(posedge clk_i); #1;
      waited++;
    end
    ar_ready_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    check_output("pending_fetch_expectations", exp_q.size(), 32'd0);
`ifdef RVFI_TRACE_EN
    check_output("pending_trace_expectations", tr_q.size(), 32'd0);
`endif
    finish_test();
  end

  initial begin
    #2_000_000;
    timeout("global_watchdog");
  end

endmodule

// File: doc/ariane.md
ARIANE -- requirements
Module: ariane

Interface
REQ-001 Parameters: TRAP_VEC, 32'h0000_0100, trap handler address; DEBUG_VEC, 32'h0000_0800, debug entry address.
REQ-002 Reset is synchronous and active-high: one clock clk_i, rising edge; reset rst_i sampled on that edge.
REQ-003 clk_i  in  1  clock.
REQ-004 rst_i  in  1  synchronous active-high reset.
REQ-005 boot_addr_i  in  32  first fetch address, sampled while rst_i=1.
REQ-006 hart_id_i  in  64  hart id; ar_id_o = hart_id_i[3:0].
REQ-007 irq_i  in  2  bit0 machine external (code 11), bit1 supervisor external (code 9), level.
REQ-008 ipi_i  in  1  software interrupt (code 3), level.
REQ-009 time_irq_i  in  1  timer interrupt (code 7), level.
REQ-010 debug_req_i  in  1  debug halt request, level.
REQ-011 ar_valid_o/ar_ready_i/ar_addr_o[31:0]/ar_id_o[3:0]: AXI-style fetch address channel, out/in/out/out.
REQ-012 r_valid_i/r_ready_o/r_data_i[31:0]/r_resp_i[1:0]: AXI-style fetch data channel, in/out/in/in.
REQ-013 mcause_o  out  32, mepc_o  out  32, debug_mode_o  out  1: architectural state.

Function
REQ-014 FSM states FETCH_REQ, FETCH_WAIT; one fetch outstanding max.
REQ-015 FETCH_REQ: ar_valid_o=1, ar_addr_o=pc; ar_ready_i=1 -> FETCH_WAIT; valid/addr held stable until handshake.
REQ-016 FETCH_WAIT: r_ready_o=1; r_valid_i=1 completes fetch -> FETCH_REQ next cycle with next pc.
REQ-017 Next-pc priority at completion, highest first: access fault, debug, MRET/DRET, interrupt, sequential pc+4 (32-bit wrap, 0xFFFF_FFFC -> 0).
REQ-018 Access fault (r_resp_i!=0): mcause=1, mepc=pc, pc=TRAP_VEC, ie=0; no retire.
REQ-019 Debug: debug_req_i=1 and debug_mode=0 -> dpc=seq pc, pc=DEBUG_VEC, debug_mode=1; insn retires.
REQ-020 r_data_i=32'h3020_0073 (MRET) -> pc=mepc, ie=1; 32'h7b20_0073 (DRET) with debug_mode=1 -> pc=dpc, debug_mode=0; DRET outside debug mode is sequential.
REQ-021 Interrupt taken when ie=1, debug_mode=0, any source high: code priority 11>3>7>9; mcause={1'b1,31'(code)}, mepc=seq pc, pc=TRAP_VEC, ie=0.
REQ-022 Interrupts and debug requests checked only at fetch completion; requests deasserted before then are lost.
REQ-023 Simultaneous debug and interrupt: debug wins, interrupt stays pending (level).

Reset
REQ-024 rst_i=1: pc<=boot_addr_i, state FETCH_REQ, ar_valid_o=0, r_ready_o=0, mcause=0, mepc=0, dpc=0, ie=1, debug_mode=0.
REQ-025 First cycle after reset release: ar_valid_o=1, ar_addr_o=boot_addr_i.
REQ-026 Reset mid-fetch abandons the transaction; late r_valid_i ignored until a new request is issued.

Configuration
REQ-027 Macro RVFI_TRACE_EN defined: outputs trace_valid_o(1), trace_pc_o(32), trace_insn_o(32), registered, pulse one cycle after each retiring completion with fetched pc and r_data_i; 0 in reset.
REQ-028 RVFI_TRACE_EN undefined: trace ports absent, all other behaviour identical.

Verification
REQ-029 Reset boot_addr_i=0x8000_0000, release, ar_ready_i/r_valid_i always 1, NOP data -> ar_addr_o 0x8000_0000, 0x8000_0004, 0x8000_0008.
REQ-030 time_irq_i=1 during fetch at 0x100 -> mcause_o=0x8000_0007, mepc_o=0x104, next ar_addr_o=0x100; then MRET data -> next ar_addr_o=0x104.
REQ-031 irq_i=2'b01 and ipi_i=1 together -> mcause_o=0x8000_000B.
REQ-032 r_resp_i=2'b10 on fetch at 0x200 -> mcause_o=1, mepc_o=0x200, next ar_addr_o=0x100, no trace pulse.
REQ-033 debug_req_i=1 with time_irq_i=1 at 0x300 -> debug_mode_o=1, ar_addr_o=0x800; DRET -> ar_addr_o=0x304, then timer trap.
REQ-034 ar_ready_i held 0 for 5 cycles -> ar_valid_o and ar_addr_o stable; rst_i pulse in FETCH_WAIT -> restart at boot_addr_i.
